// File: rtl/counter_request_cell.sv
// Counter-request stage: edge-detects plus/minus pulses into per-slot pending flags held until serviced.
// Optional macro CTR_SYNC_EN adds a two-flop synchronizer on every PLS_P/PLS_M bit.
module counter_request_cell #(
    parameter int N      = 8,
    parameter int LOST_W = 8
) (
    input  logic              CLOCK,
    input  logic              rst_,
    input  logic [N-1:0]      PLS_P,
    input  logic [N-1:0]      PLS_M,
    input  logic [N-1:0]      CNT_R,
    input  logic              GOJAM,
    input  logic              LOST_CLR,
    output logic [N-1:0]      CNT_A,
    output logic [N-1:0]      CNT_P,
    output logic [N-1:0]      CNT_M,
    output logic              ANY_A,
    output logic [LOST_W-1:0] LOST_CNT
);

    localparam int CNT_W = $clog2(2 * N + 1);
    localparam int SUM_W = ((LOST_W > CNT_W) ? LOST_W : CNT_W) + 1;
    localparam logic [SUM_W-1:0] LOST_MAX = SUM_W'({LOST_W{1'b1}});

    logic [N-1:0]      w_s_p, w_s_m;
    logic [N-1:0]      r_prev_p, r_prev_m;
    logic [N-1:0]      w_e_p, w_e_m;
    logic [N-1:0]      w_set_p, w_set_m, w_net;
    logic [N-1:0]      w_p_nxt, w_m_nxt;
    logic [N-1:0]      w_lost_p, w_lost_m;
    logic [CNT_W-1:0]  w_lost_n;
    logic [N-1:0]      r_p, r_m;
    logic [LOST_W-1:0] r_lost;

    function automatic logic [CNT_W-1:0] popcnt(input logic [N-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) c = c + CNT_W'(v[i]);
        return c;
    endfunction

    function automatic logic [LOST_W-1:0] sat_add(input logic [LOST_W-1:0] a,
                                                  input logic [CNT_W-1:0]  b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > LOST_MAX) return {LOST_W{1'b1}};
        return s[LOST_W-1:0];
    endfunction

`ifdef CTR_SYNC_EN
    logic [N-1:0] r_meta_p, r_meta_m, r_sync_p, r_sync_m;

    // Stages reset high so an input already high at reset release looks like no edge.
    always_ff @(posedge CLOCK or negedge rst_) begin
        if (!rst_) begin
            r_meta_p <= '1;
            r_meta_m <= '1;
            r_sync_p <= '1;
            r_sync_m <= '1;
        end else begin
            r_meta_p <= PLS_P;
            r_meta_m <= PLS_M;
            r_sync_p <= r_meta_p;
            r_sync_m <= r_meta_m;
        end
    end

    assign w_s_p = r_sync_p;
    assign w_s_m = r_sync_m;
`else
    assign w_s_p = PLS_P;
    assign w_s_m = PLS_M;
`endif

    always_ff @(posedge CLOCK or negedge rst_) begin
        if (!rst_) begin
            r_prev_p <= '1;
            r_prev_m <= '1;
        end else begin
            r_prev_p <= w_s_p;
            r_prev_m <= w_s_m;
        end
    end

    assign w_e_p = w_s_p & ~r_prev_p;
    assign w_e_m = w_s_m & ~r_prev_m;

    // Service clears the old request first so a same-cycle edge re-arms the slot.
    assign w_set_p = (r_p & ~CNT_R) | w_e_p;
    assign w_set_m = (r_m & ~CNT_R) | w_e_m;
    assign w_net   = w_set_p & w_set_m;
    assign w_p_nxt = GOJAM ? '0 : (w_set_p & ~w_net);
    assign w_m_nxt = GOJAM ? '0 : (w_set_m & ~w_net);

    assign w_lost_p = GOJAM ? '0 : (w_e_p & r_p & ~CNT_R);
    assign w_lost_m = GOJAM ? '0 : (w_e_m & r_m & ~CNT_R);
    assign w_lost_n = popcnt(w_lost_p) + popcnt(w_lost_m);

    always_ff @(posedge CLOCK or negedge rst_) begin
        if (!rst_) begin
            r_p    <= '0;
            r_m    <= '0;
            r_lost <= '0;
        end else begin
            r_p <= w_p_nxt;
            r_m <= w_m_nxt;
            if (LOST_CLR) r_lost <= '0;
            else          r_lost <= sat_add(r_lost, w_lost_n);
        end
    end

    assign CNT_P    = r_p;
    assign CNT_M    = r_m;
    assign CNT_A    = r_p | r_m;
    assign ANY_A    = |(r_p | r_m);
    assign LOST_CNT = r_lost;

endmodule
